// File: rtl/tt_pkg.sv
// Shared types and constants for the exhaustive truth-table response checker.
package tt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } tt_state_t;

    localparam int unsigned SETTLE_CYCLES_DEFAULT = 4;

    function automatic int unsigned n_vec(input int unsigned n_in);
        return 32'd1 << n_in;
    endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Settle counter: cleared by clear, counts while en, flags the last settle cycle.
module tt_settle_timer
    import tt_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic tc
);

    // The count runs one past the terminal value on the final settle edge.
    localparam int unsigned CW = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == CW'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/tt_response_checker.sv
// Walks every input vector through a function under test, captures y after a
// settle time and grades the captured truth table against an expected one.
module tt_response_checker
    import tt_pkg::*;
#(
    parameter int unsigned N_IN          = 3,
    parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT,
    localparam int unsigned N_VEC        = n_vec(N_IN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [N_VEC-1:0] exp_tt,
    input  logic             y_in,
    output logic [N_IN-1:0]  drv,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [N_VEC-1:0] captured_tt,
    output logic [N_IN:0]    err_count,
    output logic [N_IN-1:0]  first_err_idx
);

    tt_state_t        state;
    logic [N_IN-1:0]  idx;
    logic [N_VEC-1:0] exp_latch;
    logic             accept_start;
    logic             timer_clear;
    logic             timer_en;
    logic             settle_tc;
    logic             mismatch;
    logic             last_vec;
    logic [N_IN:0]    err_next;

    assign accept_start = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign timer_clear  = accept_start || (state == ST_SAMPLE);
    assign timer_en     = (state == ST_SETTLE);
    assign mismatch     = y_in ^ exp_latch[idx];
    assign last_vec     = (idx == N_IN'(N_VEC - 1));
    assign err_next     = err_count + {{N_IN{1'b0}}, mismatch};

    tt_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (timer_clear),
        .en    (timer_en),
        .tc    (settle_tc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            idx           <= '0;
            exp_latch     <= '0;
            drv           <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            captured_tt   <= '0;
            err_count     <= '0;
            first_err_idx <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        exp_latch     <= exp_tt;
                        idx           <= '0;
                        drv           <= '0;
                        captured_tt   <= '0;
                        err_count     <= '0;
                        first_err_idx <= '0;
                        done          <= 1'b0;
                        pass          <= 1'b0;
                        busy          <= 1'b1;
                        state         <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_tc) begin
                        state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    captured_tt[idx] <= y_in;
                    err_count        <= err_next;
                    // An empty error count means this is the lowest failing vector.
                    if (mismatch && (err_count == '0)) begin
                        first_err_idx <= idx;
                    end
                    if (last_vec) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == '0);
                    end else begin
                        idx   <= idx + 1'b1;
                        drv   <= idx + 1'b1;
                        state <= ST_SETTLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tt_response_checker.sv
// Randomised and directed bench for tt_response_checker against a cycle-count model.
module tb_tt_response_checker;

    localparam int RUN_LEN = 40;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] exp_tt;
    logic       y_in;
    logic [2:0] drv;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] captured_tt;
    logic [3:0] err_count;
    logic [2:0] first_err_idx;

    logic [7:0] fut;
    int         tests_run;
    int         tests_failed;
    bit         chk_en;

    bit         m_active;
    int         m_t;
    logic [7:0] m_exp;
    logic [7:0] m_fut;

    tt_response_checker dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .exp_tt        (exp_tt),
        .y_in          (y_in),
        .drv           (drv),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .captured_tt   (captured_tt),
        .err_count     (err_count),
        .first_err_idx (first_err_idx)
    );

    // Function under test: a truth table looked up by the applied vector.
    assign y_in = fut[drv];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        tests_run++;
        if (act !== exp_v) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Model: a run is just "m_t edges since the accepted start".
    always @(posedge clk) begin
        if (!rst_n) begin
            m_active = 1'b0;
            m_t      = 0;
        end else if (start && !(m_active && m_t < RUN_LEN)) begin
            m_active = 1'b1;
            m_t      = 0;
            m_exp    = exp_tt;
            m_fut    = fut;
        end else if (m_active && m_t < RUN_LEN) begin
            m_t++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            int         n;
            logic [7:0] mask;
            logic [7:0] diff;
            logic [7:0] e_cap;
            int         e_err;
            int         e_first;
            int         e_drv;
            bit         e_busy;
            bit         e_done;
            bit         e_pass;
            if (!m_active) begin
                e_cap = 8'h00; e_err = 0; e_first = 0; e_drv = 0;
                e_busy = 1'b0; e_done = 1'b0; e_pass = 1'b0;
            end else begin
                n       = m_t / 5;
                mask    = 8'((32'd1 << n) - 1);
                e_cap   = m_fut & mask;
                diff    = (m_fut ^ m_exp) & mask;
                e_err   = $countones(diff);
                e_first = 0;
                for (int i = 7; i >= 0; i--) if (diff[i]) e_first = i;
                e_drv   = (n > 7) ? 7 : n;
                e_busy  = (m_t < RUN_LEN);
                e_done  = (m_t == RUN_LEN);
                e_pass  = e_done && (e_err == 0);
            end
            chk("drv",           32'(drv),           32'(e_drv));
            chk("busy",          32'(busy),          32'(e_busy));
            chk("done",          32'(done),          32'(e_done));
            chk("pass",          32'(pass),          32'(e_pass));
            chk("captured_tt",   32'(captured_tt),   32'(e_cap));
            chk("err_count",     32'(err_count),     32'(e_err));
            chk("first_err_idx", 32'(first_err_idx), 32'(e_first));
        end
    end

    // Start a run, then wait (bounded) for done; optionally poke start while busy.
    task automatic run(input logic [7:0] e, input logic [7:0] f, input bit noisy_start);
        int k;
        exp_tt = e;
        fut    = f;
        start  = 1'b1;
        tick(1);
        start  = 1'b0;
        chk("start_clears_done", 32'(done), 32'd0);
        chk("start_busy",        32'(busy), 32'd1);
        k = 0;
        while (k < 100) begin
            tick(1);
            k++;
            if (done) break;
            start = noisy_start ? ($urandom_range(0, 3) == 0) : 1'b0;
            if (noisy_start && ($urandom_range(0, 7) == 0)) exp_tt = 8'($urandom);
        end
        start = 1'b0;
        chk("done_cycle", 32'(k), 32'(RUN_LEN));
        $display("[TB] run exp=%02h fut=%02h -> cap=%02h err=%0d first=%0d pass=%0b",
                 e, f, captured_tt, err_count, first_err_idx, pass);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        chk_en       = 1'b0;
        rst_n        = 1'b0;
        start        = 1'b0;
        exp_tt       = 8'h00;
        fut          = 8'hEA;
        tick(1);
        chk_en = 1'b1;
        tick(1);
        rst_n = 1'b1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_cap",  32'(captured_tt), 32'd0);

        // y = (a&b)|c matched against its own table.
        run(8'hEA, 8'hEA, 1'b0);
        chk("match_pass",  32'(pass),          32'd1);
        chk("match_cap",   32'(captured_tt),   32'hEA);
        chk("match_err",   32'(err_count),     32'd0);
        chk("match_first", 32'(first_err_idx), 32'd0);

        // Restart from DONE with an all-ones expectation.
        run(8'hFF, 8'hEA, 1'b0);
        chk("ff_pass",  32'(pass),          32'd0);
        chk("ff_err",   32'(err_count),     32'd3);
        chk("ff_first", 32'(first_err_idx), 32'd0);

        run(8'hEB, 8'hEA, 1'b0);
        chk("single_pass",  32'(pass),          32'd0);
        chk("single_err",   32'(err_count),     32'd1);
        chk("single_first", 32'(first_err_idx), 32'd0);
        chk("single_cap",   32'(captured_tt),   32'hEA);

        run(8'hEA, 8'h00, 1'b0);
        chk("stuck_err",   32'(err_count),     32'd5);
        chk("stuck_first", 32'(first_err_idx), 32'd1);
        chk("stuck_cap",   32'(captured_tt),   32'h00);
        chk("stuck_pass",  32'(pass),          32'd0);

        // Reset in the middle of a run.
        exp_tt = 8'hEA; fut = 8'hEA; start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(16);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_drv",  32'(drv),  32'd0);
        chk("midrst_err",  32'(err_count), 32'd0);
        run(8'hEA, 8'hEA, 1'b0);
        chk("after_rst_pass", 32'(pass), 32'd1);

        // start pulses and an exp_tt change during a run are ignored.
        exp_tt = 8'hEA; fut = 8'hEA; start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(9);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(1);
        exp_tt = 8'h00;
        tick(13);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(14);
        chk("ignore_notdone", 32'(done), 32'd0);
        tick(1);
        chk("ignore_done", 32'(done), 32'd1);
        chk("ignore_pass", 32'(pass), 32'd1);
        chk("ignore_cap",  32'(captured_tt), 32'hEA);

        for (int r = 0; r < 8; r++) begin
            run(8'($urandom), 8'($urandom), 1'b1);
        end
        tick(3);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/tt_response_checker.md
Name: tt_response_checker

Overview:
- Hardware counterpart of the exhaustive 3-input stimulus sequence used in the boolean-expression labs.
- Drives every input combination (a,b,c) into a combinational function under test and samples its output y after a settle time.
- Builds the captured truth table, compares it bit-by-bit against an expected truth table and reports pass/fail, error count and first failing vector.
- Sits on the lab board between the function under test and the LEDs/switches.

Parameters:
- N_IN, 3, number of function inputs; the vector count is N_VEC = 2**N_IN.
- SETTLE_CYCLES, 4, cycles the vector is held before y is sampled; minimum 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle run request; sampled in IDLE or DONE only.
- exp_tt  in  N_VEC  expected truth table; bit i is the expected y for vector i.
- y_in  in  1  output of the function under test.
- drv  out  N_IN  applied vector; drv[2]=a, drv[1]=b, drv[0]=c; vector index i = {a,b,c}.
- busy  out  1  run in progress.
- done  out  1  run complete; held until the next start or reset.
- pass  out  1  valid when done=1; 1 iff err_count==0.
- captured_tt  out  N_VEC  sampled y per vector.
- err_count  out  N_IN+1  number of mismatching vectors, range 0..N_VEC.
- first_err_idx  out  N_IN  index of the lowest mismatching vector; 0 if there is none.

Behaviour:
- Reset (rst_n=0 at a clock edge): state=IDLE. drv, busy, done, pass, captured_tt, err_count, first_err_idx, internal idx, cnt and exp_tt latch are all cleared to 0. Reset takes priority over every other event, including mid-run.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE/DONE with start=1 at edge E0:
  - latch exp_tt; idx<=0, drv<=0, cnt<=0.
  - clear captured_tt, err_count, first_err_idx, done, pass.
  - busy<=1; state<=SETTLE.
- SETTLE: cnt<=cnt+1 each edge. On the edge where cnt==SETTLE_CYCLES-1, state<=SAMPLE.
- SAMPLE (one edge):
  - captured_tt[idx]<=y_in.
  - On mismatch with latched exp[idx]: err_count++; if this is the first error, first_err_idx<=idx.
  - If idx==N_VEC-1: state<=DONE, busy<=0, done<=1, pass<=(final err_count==0); drv holds the last vector.
  - Otherwise: idx<=idx+1, drv<=idx+1, cnt<=0, state<=SETTLE.
- Timing:
  - y is sampled SETTLE_CYCLES+1 edges after drv changes.
  - Each vector takes SETTLE_CYCLES+1 cycles.
  - done rises at edge E0 + N_VEC*(SETTLE_CYCLES+1); with the defaults that is E40.
- start while busy is ignored. exp_tt changes during a run have no effect because the value is latched.
- start in DONE restarts the run exactly as from IDLE.
- idx does not wrap within a run; the terminal vector ends the run.
- Arithmetic: err_count saturation is unnecessary because its width covers N_VEC. All counters are unsigned.

Decomposition:
- Package tt_pkg holds:
  - the state enum (IDLE, SETTLE, SAMPLE, DONE);
  - the N_VEC derivation function;
  - the default SETTLE_CYCLES constant.
- One sub-module is natural: tt_settle_timer. It is a load/count-to-SETTLE_CYCLES-1 counter with a terminal-count output, instantiated once.
- The FSM, capture and compare logic stay in tt_response_checker.

Test Plan:
- Expected match: function under test y=(a&b)|c, exp_tt=8'hEA, start pulse -> drv steps 0..7, busy high for 40 cycles, then done=1, pass=1, captured_tt=8'hEA, err_count=0, first_err_idx=0.
- Single mismatch: same function, exp_tt=8'hEB -> done at E40, pass=0, err_count=1, first_err_idx=0, captured_tt=8'hEA.
- Stuck-at-0 function under test (y_in=0), exp_tt=8'hEA -> err_count=5, first_err_idx=1, captured_tt=8'h00, pass=0.
- Reset mid-run: rst_n=0 at E17 for one cycle -> next cycle shows state IDLE and all outputs 0. A later start completes normally in 40 cycles.
- start pulsed at E10 and E25 during a run, and exp_tt changed to 8'h00 at E12 -> no restart; done still at E40 with the E0-latched comparison (pass=1 for the matching function).
- Restart from DONE: after pass, start again with exp_tt=8'hFF -> done, pass, captured_tt and err_count clear on the start edge. The run ends at +40 with err_count=3, first_err_idx=0.
